aes_inv_round_ctrl: RTL and testbench



---
 rtl/aes_pkg.sv | 43 ++++
 rtl/aes_inv_round_ctrl_if.sv | 23 ++
 rtl/aes_inv_mix_columns.sv | 20 ++
 rtl/aes_inv_round.sv | 23 ++
 rtl/aes_inv_round_ctrl.sv | 65 ++++++
 tb/tb_aes_inv_round_ctrl.sv | 282 ++++++++++++++++++++++++++++
 6 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared types, constants and GF(2^8) helpers for the AES inverse round logic
// Contents: FSM state enum, AES-128 round/key-index constants, reduction constant,
//           row-major byte-position helper, GF multiply/inverse and inverse S-box.
package aes_pkg;
  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_e;
  localparam int AES_NR = 10;
  localparam int AES_RK_W = 4;
  localparam logic [7:0] GF_POLY = 8'h1B;
  // s[r][c] lives at bits [127-32r-8c -: 8], i.e. LSB at 120-32r-8c
  function automatic int byte_lsb(int r, int c);
    return 120 - 32 * r - 8 * c;
  endfunction
  function automatic logic [7:0] xtime(logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? GF_POLY : 8'h00);
  endfunction
  function automatic logic [7:0] gf_mul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ x : p;
      x = xtime(x);
    end
    return p;
  endfunction
  // a^254 == a^-1 in GF(2^8), and maps 0 to 0 as the S-box requires
  function automatic logic [7:0] gf_inv(logic [7:0] a);
    logic [7:0] a2, a3, a12, a15, a60, a63, a252;
    a2 = gf_mul(a, a);
    a3 = gf_mul(a2, a);
    a12 = gf_mul(gf_mul(a3, a3), gf_mul(a3, a3));
    a15 = gf_mul(a12, a3);
    a60 = gf_mul(gf_mul(a15, a15), gf_mul(a15, a15));
    a63 = gf_mul(a60, a3);
    a252 = gf_mul(gf_mul(a63, a63), gf_mul(a63, a63));
    return gf_mul(a252, a2);
  endfunction
  // inverse affine transform followed by field inversion
  function automatic logic [7:0] inv_sbox(logic [7:0] x);
    return gf_inv({x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05);
  endfunction
endpackage

// File: rtl/aes_inv_round_ctrl_if.sv
// aes_inv_round_ctrl_if: block handshake, round-key fetch and status bundle
// master: the decryption controller (drives in_ready, rk_addr, out_*, busy, round)
// slave:  the surrounding FIFO / key store / output stage
interface aes_inv_round_ctrl_if #(parameter int RKW = 4);
  logic in_valid;
  logic in_ready;
  logic [127:0] in_data;
  logic [RKW-1:0] rk_addr;
  logic [127:0] rk_data;
  logic out_valid;
  logic out_ready;
  logic [127:0] out_data;
  logic busy;
  logic [RKW-1:0] round;
  modport master (
    input in_valid, in_data, rk_data, out_ready,
    output in_ready, rk_addr, out_valid, out_data, busy, round
  );
  modport slave (
    output in_valid, in_data, rk_data, out_ready,
    input in_ready, rk_addr, out_valid, out_data, busy, round
  );
endinterface

// File: rtl/aes_inv_mix_columns.sv
// aes_inv_mix_columns: combinational AES InvMixColumns on a row-major packed state
// st_i: input state, st_o: each column multiplied by the {0e,0b,0d,09} circulant
module aes_inv_mix_columns
  import aes_pkg::*;
(
  input  logic [127:0] st_i,
  output logic [127:0] st_o
);
  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] a0, a1, a2, a3;
    assign a0 = st_i[byte_lsb(0, c) +: 8];
    assign a1 = st_i[byte_lsb(1, c) +: 8];
    assign a2 = st_i[byte_lsb(2, c) +: 8];
    assign a3 = st_i[byte_lsb(3, c) +: 8];
    assign st_o[byte_lsb(0, c) +: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
    assign st_o[byte_lsb(1, c) +: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
    assign st_o[byte_lsb(2, c) +: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
    assign st_o[byte_lsb(3, c) +: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
  end
endmodule

// File: rtl/aes_inv_round.sv
// aes_inv_round: combinational AES inverse round (InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns)
// state_i: current state, rk_i: round key, last_i: skip InvMixColumns, state_o: next state
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] state_i,
  input  logic [127:0] rk_i,
  input  logic         last_i,
  output logic [127:0] state_o
);
  logic [127:0] sb;
  logic [127:0] ark;
  logic [127:0] imc;
  // row r rotates right by r: out[r][c] = in[r][(c - r) mod 4]
  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < 4; c++) begin : g_col
      assign sb[byte_lsb(r, c) +: 8] = inv_sbox(state_i[byte_lsb(r, (c + 4 - r) % 4) +: 8]);
    end
  end
  assign ark = sb ^ rk_i;
  aes_inv_mix_columns u_imc (.st_i(ark), .st_o(imc));
  assign state_o = last_i ? ark : imc;
endmodule

// File: rtl/aes_inv_round_ctrl.sv
// aes_inv_round_ctrl: iterative AES-128 decryption sequencer, one inverse round per cycle
// clk, rst_n: clock and asynchronous active-low reset
// bus (master): in_valid/in_ready/in_data ciphertext, rk_addr/rk_data round-key fetch,
//               out_valid/out_ready/out_data plaintext, busy and round status
module aes_inv_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR  = AES_NR,
  parameter int RKW = AES_RK_W
) (
  input logic clk,
  input logic rst_n,
  aes_inv_round_ctrl_if.master bus
);
  state_e st_q, st_d;
  logic [127:0] blk_q, blk_d, rnd_out;
  logic [RKW-1:0] round_q, round_d;
  aes_inv_round u_round (
    .state_i(blk_q),
    .rk_i   (bus.rk_data),
    .last_i (st_q == FINAL),
    .state_o(rnd_out)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q <= IDLE;
      blk_q <= '0;
      round_q <= '0;
    end else begin
      st_q <= st_d;
      blk_q <= blk_d;
      round_q <= round_d;
    end
  end
  always_comb begin
    st_d = st_q;
    blk_d = blk_q;
    round_d = round_q;
    case (st_q)
      IDLE: if (bus.in_valid) begin
        st_d = ROUND;
        blk_d = bus.in_data ^ bus.rk_data;
        round_d = RKW'(NR - 1);
      end
      ROUND: begin
        blk_d = rnd_out;
        st_d = round_q == RKW'(1) ? FINAL : ROUND;
        round_d = round_q - 1'b1;
      end
      FINAL: begin
        blk_d = rnd_out;
        st_d = DONE;
      end
      DONE: if (bus.out_ready) st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end
  assign bus.in_ready = st_q == IDLE;
  assign bus.out_valid = st_q == DONE;
  assign bus.out_data = blk_q;
  assign bus.busy = st_q != IDLE;
  assign bus.round = round_q;
  // round_q is already 0 in FINAL and DONE, so only IDLE needs an override
  assign bus.rk_addr = st_q == IDLE ? RKW'(NR) : round_q;
endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// tb_aes_inv_round_ctrl: directed and randomized scoreboard bench for aes_inv_round_ctrl
module tb_aes_inv_round_ctrl;
  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  aes_inv_round_ctrl_if #(.RKW(4)) bus ();
  aes_inv_round_ctrl #(.NR(10), .RKW(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  logic [127:0] rk_mem [11];
  logic [7:0] sbox [256];
  logic [7:0] isbox [256];
  assign bus.rk_data = (bus.rk_addr <= 4'd10) ? rk_mem[bus.rk_addr] : '0;
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  logic [127:0] exp_q [$];
  int acc_q [$];
  int hs_q [$];
  logic stall_prev = 1'b0;
  logic [127:0] held = '0;
  bit rnd = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask
  task automatic chkn(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask
  task automatic fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: bounded wait expired, expected DUT event", name);
  endtask
  function automatic logic [7:0] xt(logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] mul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p = '0;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction
  function automatic logic [7:0] gb(logic [127:0] s, int r, int c);
    return s[127-32*r-8*c -: 8];
  endfunction
  function automatic logic [127:0] to_rm(logic [127:0] v);
    logic [127:0] o = '0;
    for (int k = 0; k < 16; k++) o[127-32*(k%4)-8*(k/4) -: 8] = v[127-8*k -: 8];
    return o;
  endfunction
  task automatic build_tables();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] iv;
      logic [7:0] s;
      iv = 8'h00;
      for (int y = 1; y < 256; y++) if (mul(8'(x), 8'(y)) == 8'h01) iv = 8'(y);
      s = iv ^ {iv[6:0], iv[7]} ^ {iv[5:0], iv[7:6]} ^ {iv[4:0], iv[7:5]} ^ {iv[3:0], iv[7:4]} ^ 8'h63;
      sbox[x] = s;
      isbox[s] = 8'(x);
    end
  endtask
  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0] rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]], sbox[tmp[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int k = 0; k <= 10; k++)
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) rk_mem[k][127-32*r-8*c -: 8] = w[4*k+c][31-8*r -: 8];
  endtask
  function automatic logic [127:0] inv_cipher(input logic [127:0] ct);
    logic [127:0] s;
    logic [127:0] t = '0;
    logic [7:0] a [4];
    s = ct ^ rk_mem[10];
    for (int rd = 9; rd >= 0; rd--) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) t[127-32*r-8*c -: 8] = isbox[gb(s, r, (c + 4 - r) % 4)];
      t = t ^ rk_mem[rd];
      s = t;
      if (rd > 0)
        for (int c = 0; c < 4; c++) begin
          for (int r = 0; r < 4; r++) a[r] = gb(t, r, c);
          for (int r = 0; r < 4; r++)
            s[127-32*r-8*c -: 8] = mul(a[r], 8'h0e) ^ mul(a[(r+1)%4], 8'h0b) ^ mul(a[(r+2)%4], 8'h0d) ^ mul(a[(r+3)%4], 8'h09);
        end
    end
    return s;
  endfunction
  always @(negedge clk) begin
    if (!rst_n) stall_prev = 1'b0;
    else begin
      if (bus.in_valid && bus.in_ready) begin
        acc_q.push_back(cyc);
        chk1("accept_while_busy", bus.busy, 1'b0);
      end
      if (stall_prev) begin
        chk1("stall_valid", bus.out_valid, 1'b1);
        chk("stall_data", bus.out_data, held);
      end
      if (bus.out_valid && bus.out_ready) begin
        hs_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL spurious_output: got %h, expected no output", bus.out_data);
        end else chk("plaintext", bus.out_data, exp_q.pop_front());
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      held = bus.out_data;
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd) bus.out_ready = $urandom_range(0, 3) != 0;
  endtask
  task automatic send(input logic [127:0] ct, input logic [127:0] pt, input bit hold);
    bit acc = 1'b0;
    bus.in_data = ct;
    bus.in_valid = 1'b1;
    exp_q.push_back(pt);
    for (int t = 0; t < 2000 && !acc; t++) begin
      @(negedge clk);
      acc = bus.in_ready;
      tick();
    end
    if (!acc) fail("accept_timeout");
    if (!hold) bus.in_valid = 1'b0;
  endtask
  task automatic drain();
    bit done = 1'b0;
    for (int t = 0; t < 3000 && !done; t++) begin
      @(negedge clk);
      done = exp_q.size() == 0;
      tick();
    end
    if (!done) begin
      fail("drain_timeout");
      exp_q.delete();
    end
  endtask
  task automatic chk_reset(input string tag);
    chk1({tag, "_in_ready"}, bus.in_ready, 1'b1);
    chk1({tag, "_out_valid"}, bus.out_valid, 1'b0);
    chk1({tag, "_busy"}, bus.busy, 1'b0);
    chkn({tag, "_rk_addr"}, int'(bus.rk_addr), 10);
    chkn({tag, "_round"}, int'(bus.round), 0);
    chk({tag, "_out_data"}, bus.out_data, '0);
  endtask
  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    bit got;
    logic [127:0] key, ct;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b1;
    for (int k = 0; k <= 10; k++) rk_mem[k] = '0;
    build_tables();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset("reset");
    tick();
    rst_n = 1'b1;
    expand_key(KEY_C1);
    bus.in_data = to_rm(CT_C1);
    bus.in_valid = 1'b1;
    exp_q.push_back(to_rm(PT_C1));
    @(negedge clk);
    chk1("c1_accept_ready", bus.in_ready, 1'b1);
    chkn("c1_rk_addr_accept", int'(bus.rk_addr), 10);
    tick();
    bus.in_valid = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
      chk1("c1_out_valid", bus.out_valid, i == 11);
      chk1("c1_busy", bus.busy, 1'b1);
      if (i <= 10) chkn("c1_rk_addr", int'(bus.rk_addr), 10 - i);
      if (i <= 10) chkn("c1_round", int'(bus.round), 10 - i);
      tick();
    end
    drain();
    bus.out_ready = 1'b0;
    acc_q.delete();
    hs_q.delete();
    send(to_rm(CT_C1), to_rm(PT_C1), 1'b1);
    got = 1'b0;
    for (int t = 0; t < 50 && !got; t++) begin
      @(negedge clk);
      got = bus.out_valid;
      if (!got) tick();
    end
    if (!got) fail("bp_wait_valid");
    for (int i = 0; i < 20; i++) begin
      chk1("bp_out_valid", bus.out_valid, 1'b1);
      chk("bp_out_data", bus.out_data, to_rm(PT_C1));
      chk1("bp_in_ready", bus.in_ready, 1'b0);
      tick();
      @(negedge clk);
    end
    chkn("bp_accepts_during_stall", acc_q.size(), 1);
    tick();
    bus.out_ready = 1'b1;
    send(to_rm(CT_C1), to_rm(PT_C1), 1'b0);
    drain();
    if (acc_q.size() == 2 && hs_q.size() == 2) chkn("bp_reaccept_cycle", acc_q[1], hs_q[0] + 1);
    else fail("bp_handshake_count");
    acc_q.delete();
    for (int i = 0; i < 4; i++) begin
      ct = {$urandom, $urandom, $urandom, $urandom};
      send(ct, inv_cipher(ct), i < 3);
    end
    drain();
    if (acc_q.size() == 4) for (int i = 0; i < 3; i++) chkn("b2b_spacing", acc_q[i+1] - acc_q[i], 12);
    else fail("b2b_accept_count");
    send(to_rm(CT_C1), to_rm(PT_C1), 1'b0);
    got = 1'b0;
    for (int t = 0; t < 30 && !got; t++) begin
      @(negedge clk);
      got = bus.busy && bus.round == 4'd5 && !bus.out_valid;
      if (!got) tick();
    end
    if (!got) fail("mid_reset_wait_round5");
    #1 rst_n = 1'b0;
    #1;
    chk_reset("async_reset");
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    send(to_rm(CT_C1), to_rm(PT_C1), 1'b0);
    drain();
    for (int k = 0; k <= 10; k++) rk_mem[k] = '0;
    send('0, inv_cipher('0), 1'b0);
    drain();
    rnd = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      ct = {$urandom, $urandom, $urandom, $urandom};
      expand_key(key);
      repeat ($urandom_range(0, 3)) tick();
      send(ct, inv_cipher(ct), 1'b0);
      drain();
    end
    rnd = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
